// File: rtl/cd_mult_pkg.sv
// Shared definitions for the iterative carry-disregard multiplier.
package cd_mult_pkg;

  // Controller states; encodings are fixed so waveform and debug tooling stay stable.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } cd_state_e;

  // Ceiling log2 with a floor of 1, so a single-row multiplier still gets a counter bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r = r + 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cd_row_acc.sv
// One partial-product row folded into the accumulator, either XOR-merged
// (carries dropped) or added exactly.
module cd_row_acc
  import cd_mult_pkg::*;
#(
  parameter int unsigned A_W   = 8,
  parameter int unsigned B_W   = 4,
  parameter int unsigned CNT_W = 2
) (
  input  logic [A_W+B_W-1:0] acc_i,
  input  logic [A_W-1:0]     a_i,
  input  logic               b_bit_i,
  input  logic [CNT_W-1:0]   row_i,
  input  logic               cd_sel_i,
  output logic [A_W+B_W-1:0] acc_next_o
);

  localparam int unsigned R_W = A_W + B_W;

  logic [R_W-1:0] pp;

  // Build the shifted row and merge it; truncation is safe because the
  // running sum never exceeds A_W+row+1 bits.
  always_comb begin
    pp = R_W'(a_i & {A_W{b_bit_i}}) << row_i;
    if (cd_sel_i) begin
      acc_next_o = acc_i ^ pp;
    end else begin
      acc_next_o = acc_i + pp;
    end
  end

endmodule

// File: rtl/cd_mult_seq.sv
// Iterative carry-disregard approximate multiplier: one multiplier bit per
// clock, with the low CD_ROWS rows XOR-merged when approximate mode is set.
module cd_mult_seq
  import cd_mult_pkg::*;
#(
  parameter int unsigned A_W     = 8,
  parameter int unsigned B_W     = 4,
  parameter int unsigned CD_ROWS = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     a_in,
  input  logic [B_W-1:0]     b_in,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] r_out,
  output logic               busy
);

  localparam int unsigned R_W   = A_W + B_W;
  localparam int unsigned CNT_W = clog2(B_W);
  localparam logic [CNT_W-1:0] LastRow = CNT_W'(B_W - 1);

  cd_state_e        state_q, state_d;
  logic [A_W-1:0]   a_q;
  logic [B_W-1:0]   b_q;
  logic             approx_q;
  logic [R_W-1:0]   acc_q;
  logic [CNT_W-1:0] row_q;

  logic             load;
  logic             step;
  logic             cd_sel;
  logic [R_W-1:0]   acc_next;

  // Current row is carry-disregard only in approximate mode and below CD_ROWS.
  always_comb begin
    cd_sel = approx_q && (32'(row_q) < CD_ROWS);
  end

  cd_row_acc #(
    .A_W  (A_W),
    .B_W  (B_W),
    .CNT_W(CNT_W)
  ) u_row_acc (
    .acc_i     (acc_q),
    .a_i       (a_q),
    .b_bit_i   (b_q[row_q]),
    .row_i     (row_q),
    .cd_sel_i  (cd_sel),
    .acc_next_o(acc_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode; in DONE the ready path is combinational
  // from out_ready so a new transaction can start on the drain edge.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        busy = 1'b1;
        step = 1'b1;
        if (row_q == LastRow) begin
          state_d = StDone;
        end
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            load    = 1'b1;
            state_d = StRun;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Operand capture on acceptance, then one row per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      approx_q <= 1'b0;
      acc_q    <= '0;
      row_q    <= '0;
    end else if (load) begin
      a_q      <= a_in;
      b_q      <= b_in;
      approx_q <= approx_en;
      acc_q    <= '0;
      row_q    <= '0;
    end else if (step) begin
      acc_q <= acc_next;
      row_q <= row_q + 1'b1;
    end
  end

  always_comb begin
    r_out = acc_q;
  end

endmodule

// File: tb/tb_cd_mult_seq.sv
// Directed and random checks for cd_mult_seq; three instances (CD_ROWS=3,4,0)
// share the same stimulus and run in lockstep.
module tb_cd_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  a_in;
  logic [3:0]  b_in;
  logic        approx_en;
  logic        out_ready;

  logic        in_ready,  out_valid,  busy;
  logic        in_ready4, out_valid4, busy4;
  logic        in_ready0, out_valid0, busy0;
  logic [11:0] r_out, r4, r0;

  int n_cmp;
  int n_bad;

  cd_mult_seq #(.A_W(8), .B_W(4), .CD_ROWS(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .approx_en(approx_en), .out_valid(out_valid),
    .out_ready(out_ready), .r_out(r_out), .busy(busy)
  );

  cd_mult_seq #(.A_W(8), .B_W(4), .CD_ROWS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a_in(a_in), .b_in(b_in), .approx_en(approx_en), .out_valid(out_valid4),
    .out_ready(out_ready), .r_out(r4), .busy(busy4)
  );

  cd_mult_seq #(.A_W(8), .B_W(4), .CD_ROWS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a_in(a_in), .b_in(b_in), .approx_en(approx_en), .out_valid(out_valid0),
    .out_ready(out_ready), .r_out(r0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: row-by-row XOR for the low cdr rows in approximate mode, exact add otherwise.
  function automatic logic [11:0] model(input logic [7:0] a, input logic [3:0] b,
                                        input logic ap, input int cdr);
    logic [11:0] acc;
    logic [11:0] pp;
    acc = 12'd0;
    for (int i = 0; i < 4; i++) begin
      pp = b[i] ? (12'(a) << i) : 12'd0;
      if (ap && i < cdr) acc = acc ^ pp;
      else acc = acc + pp;
    end
    return acc;
  endfunction

  // Drive one transaction from IDLE and collect all three results; lat counts
  // edges from acceptance to out_valid (capped at 20).
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input logic ap,
                        output logic [11:0] res, output logic [11:0] res4,
                        output logic [11:0] res0, output int lat);
    int wait_cyc;
    a_in = a; b_in = b; approx_en = ap; in_valid = 1'b1; out_ready = 1'b0;
    wait_cyc = 0;
    while (!in_ready && wait_cyc < 20) begin
      @(posedge clk); #1; wait_cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; a_in = 8'h00; b_in = 4'h0; approx_en = ~ap;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    res = r_out; res4 = r4; res0 = r0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a_in = 8'h00; b_in = 4'h0;
    approx_en = 1'b0; out_ready = 1'b0;
    #3;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      $display("FAIL reset_flags got=%b want=100", {in_ready, out_valid, busy}); n_bad++;
    end
    n_cmp++;
    if (r_out !== 12'h000) begin
      $display("FAIL reset_r_out got=%h want=000", r_out); n_bad++;
    end
    n_cmp++;
    if ({in_ready4, out_valid4, busy4, in_ready0, out_valid0, busy0} !== 6'b100100
        || {r4, r0} !== 24'h0) begin
      $display("FAIL reset_other got=%b %h %h want=100100 000 000",
               {in_ready4, out_valid4, busy4, in_ready0, out_valid0, busy0}, r4, r0);
      n_bad++;
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      $display("FAIL idle_after_reset got=%b want=100", {in_ready, out_valid, busy}); n_bad++;
    end
  endtask

  task automatic test_directed();
    logic [11:0] r, ra, rb;
    int lat;
    run_op(8'hFF, 4'hF, 1'b1, r, ra, rb, lat);
    n_cmp++;
    if (r !== 12'hAF5) begin $display("FAIL ff_f_approx got=%h want=AF5", r); n_bad++; end
    n_cmp++;
    if (lat !== 4) begin $display("FAIL latency got=%0d want=4", lat); n_bad++; end
    n_cmp++;
    if (ra !== 12'h505) begin $display("FAIL ff_f_cd4 got=%h want=505", ra); n_bad++; end
    n_cmp++;
    if (rb !== 12'hEF1) begin $display("FAIL ff_f_cd0 got=%h want=EF1", rb); n_bad++; end
    run_op(8'hFF, 4'hF, 1'b0, r, ra, rb, lat);
    n_cmp++;
    if (r !== 12'hEF1) begin $display("FAIL ff_f_exact got=%h want=EF1", r); n_bad++; end
    n_cmp++;
    if (ra !== 12'hEF1) begin $display("FAIL ff_f_exact_cd4 got=%h want=EF1", ra); n_bad++; end
    run_op(8'h03, 4'h3, 1'b1, r, ra, rb, lat);
    n_cmp++;
    if (r !== 12'h005) begin $display("FAIL 3x3_approx got=%h want=005", r); n_bad++; end
    n_cmp++;
    if (rb !== 12'h009) begin $display("FAIL 3x3_cd0 got=%h want=009", rb); n_bad++; end
    run_op(8'h03, 4'h3, 1'b0, r, ra, rb, lat);
    n_cmp++;
    if (r !== 12'h009) begin $display("FAIL 3x3_exact got=%h want=009", r); n_bad++; end
  endtask

  task automatic test_random_ops();
    logic [11:0] r, ra, rb;
    logic [7:0] a;
    logic [3:0] b;
    logic ap;
    int lat;
    for (int k = 0; k < 1000; k++) begin
      a = 8'($urandom_range(0, 255));
      b = 4'($urandom_range(0, 15));
      ap = 1'($urandom_range(0, 1));
      run_op(a, b, ap, r, ra, rb, lat);
      n_cmp++;
      if (rb !== 12'(a) * 12'(b)) begin
        $display("FAIL cd0_exact a=%h b=%h got=%h want=%h", a, b, rb, 12'(a) * 12'(b));
        n_bad++;
      end
      n_cmp++;
      if (r !== model(a, b, ap, 3) || ra !== model(a, b, ap, 4)) begin
        $display("FAIL rand_approx a=%h b=%h ap=%b got=%h/%h want=%h/%h", a, b, ap,
                 r, ra, model(a, b, ap, 3), model(a, b, ap, 4));
        n_bad++;
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad_hold;
    a_in = 8'hFF; b_in = 4'hF; approx_en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    bad_hold = 0;
    for (int k = 0; k < 10; k++) begin
      if (r_out !== 12'hAF5 || {out_valid, in_ready, busy} !== 3'b101) bad_hold++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bad_hold !== 0) begin
      $display("FAIL hold_stable got=%0d unstable cycles want=0 (r_out=%h)", bad_hold, r_out);
      n_bad++;
    end
    out_ready = 1'b1; in_valid = 1'b1; a_in = 8'h02; b_in = 4'h5; approx_en = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b11) begin
      $display("FAIL b2b_ready got=%b want=11", {in_ready, out_valid}); n_bad++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if ({out_valid, busy, in_ready} !== 3'b010) begin
      $display("FAIL b2b_run got=%b want=010", {out_valid, busy, in_ready}); n_bad++;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_cmp++;
    if (lat !== 4) begin $display("FAIL b2b_latency got=%0d want=4", lat); n_bad++; end
    n_cmp++;
    if (r_out !== 12'h00A) begin $display("FAIL b2b_result got=%h want=00A", r_out); n_bad++; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [11:0] r, ra, rb;
    int lat;
    a_in = 8'hFF; b_in = 4'hF; approx_en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b1) begin $display("FAIL mid_busy got=%b want=1", busy); n_bad++; end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100 || r_out !== 12'h000) begin
      $display("FAIL async_reset got=%b %h want=100 000", {in_ready, out_valid, busy}, r_out);
      n_bad++;
    end
    rst_n = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin $display("FAIL no_result got=%b want=0", out_valid); n_bad++; end
    run_op(8'h10, 4'h1, 1'b1, r, ra, rb, lat);
    n_cmp++;
    if (r !== 12'h010 || lat !== 4) begin
      $display("FAIL after_reset got=%h lat=%0d want=010 lat=4", r, lat); n_bad++;
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] q3[$];
    logic [11:0] q4[$];
    logic [11:0] q0[$];
    logic [7:0] av[40];
    logic [3:0] bv[40];
    logic       pv[40];
    logic [11:0] e3, e4, e0;
    int sent, got, cyc;
    for (int k = 0; k < 40; k++) begin
      av[k] = 8'($urandom_range(0, 255));
      bv[k] = 4'($urandom_range(0, 15));
      pv[k] = 1'($urandom_range(0, 1));
    end
    sent = 0; got = 0; cyc = 0;
    while (got < 40 && cyc < 3000) begin
      out_ready = ($urandom_range(0, 2) != 0);
      if (sent < 40 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; a_in = av[sent]; b_in = bv[sent]; approx_en = pv[sent];
      end else begin
        in_valid = 1'b0; a_in = 8'($urandom_range(0, 255)); b_in = 4'($urandom_range(0, 15));
      end
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q3.size() == 0) begin
          $display("FAIL stream_extra got=%h want=none", r_out); n_bad++;
        end else begin
          e3 = q3.pop_front(); e4 = q4.pop_front(); e0 = q0.pop_front();
          if (r_out !== e3 || r4 !== e4 || r0 !== e0) begin
            $display("FAIL stream_item%0d got=%h/%h/%h want=%h/%h/%h", got,
                     r_out, r4, r0, e3, e4, e0);
            n_bad++;
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q3.push_back(model(av[sent], bv[sent], pv[sent], 3));
        q4.push_back(model(av[sent], bv[sent], pv[sent], 4));
        q0.push_back(model(av[sent], bv[sent], pv[sent], 0));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (got !== 40 || sent !== 40) begin
      $display("FAIL stream_count got=%0d sent=%0d want=40/40", got, sent); n_bad++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random_ops();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cd_mult_seq.md
Name: cd_mult_seq

Overview:
Parametrised, iterative carry-disregard approximate multiplier, successor to the fixed 8x4 combinational carry-disregard multipliers.
- Processes one multiplier bit (one partial-product row) per clock.
- In approximate mode, the low CD_ROWS rows are merged by XOR with all carries dropped. The remaining rows are added exactly.
- Runtime mode input selects approximate or fully exact operation per transaction.
- Sits between operand producers and error-analysis/accumulator logic, with valid/ready handshakes on both sides.

Parameters:
A_W, 8, multiplicand width (>=2)
B_W, 4, multiplier width (>=1); also the number of rows and the compute latency
CD_ROWS, 3, number of low rows (0..B_W) merged carry-disregard when approximate mode is active

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand transaction valid
in_ready  out  1  block can accept operands
a_in  in  A_W  multiplicand
b_in  in  B_W  multiplier
approx_en  in  1  1 = carry-disregard on rows 0..CD_ROWS-1; 0 = exact product
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
r_out  out  A_W+B_W  product (approximate or exact)
busy  out  1  high in RUN or DONE

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, r_out=0, busy=0, row counter=0, internal operand/mode registers=0.
- Reset mid-operation aborts immediately. No result is produced; the block returns to IDLE.
- States:
  - IDLE: in_ready=1.
  - RUN: in_ready=0, busy=1.
  - DONE: out_valid=1, busy=1.
- IDLE -> RUN on in_valid&in_ready. That edge latches a_in, b_in, approx_en; clears acc and row counter i.
- RUN, each cycle, for row i:
  - pp = (A & {A_W{B[i]}}) zero-extended to A_W+B_W, shifted left by i.
  - If approx and i<CD_ROWS: acc <= acc ^ pp.
  - Otherwise: acc <= acc + pp, full carry propagation, truncated to A_W+B_W.
  - i increments. After row B_W-1: RUN -> DONE.
- Width rule: the truncation never discards a set bit. After row i, acc < 2^(A_W+i+1), so no overflow is possible.
- Latency: out_valid rises exactly B_W cycles after the acceptance edge. No zero-skip; latency is data-independent.
- DONE: r_out holds the final acc. r_out and out_valid are stable while out_ready=0.
- DONE + out_ready, in_valid=0: -> IDLE, out_valid=0.
- DONE + out_ready + in_valid: back-to-back. in_ready = (IDLE) | (DONE & out_ready), combinationally. The new operands are latched and the FSM goes directly to RUN. Throughput is one result per B_W+1 cycles.
- Operand changes on a_in/b_in/approx_en while not accepting are ignored.
- Degenerate modes:
  - CD_ROWS=0, or approx_en=0: bit-exact A*B.
  - CD_ROWS=B_W with approx_en=1: pure XOR (carry-less) product.
- in_valid may drop without acceptance; there is no protocol requirement on the producer.

Decomposition:
- Shared header/package cd_mult_pkg: FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2), and a counter-width function clog2 for the row counter.
- One natural sub-module, cd_row_acc (combinational): inputs acc, A, b_bit, row index, cd_sel; output next acc (XOR-merge or exact add).
- Top holds only the FSM, operand/mode registers, counter and handshake.

Test Plan:
- Default params, A=0xFF, B=0xF, approx_en=1 -> r_out=0xAF5, out_valid exactly 4 cycles after the accept edge.
- Same operands, approx_en=0 -> r_out=0xEF1 (3825); A=0x03, B=0x3, approx_en=1 -> r_out=0x005; approx_en=0 -> 0x009.
- Instance with CD_ROWS=4, A=0xFF, B=0xF, approx_en=1 -> r_out=0x505. Instance with CD_ROWS=0, 1000 random operands -> r_out == A*B in every case.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> r_out/out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1 (A=0x02, B=0x5, approx) -> same-cycle acceptance, next result 0x00A after 4 more cycles.
- Drive rst_n low during RUN row 2 -> outputs return immediately (asynchronously) to reset values. After release, the next transaction A=0x10, B=0x1 -> r_out=0x010.
- Random stream with random in_valid/out_ready gaps against a reference model -> no lost or duplicated transactions, results in order.
